// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encoding and the bit-period calculation.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    function automatic int calc_bps_cnt(input longint clk_freq, input longint bps);
        return int'(clk_freq / bps);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO holding characters waiting for the UART transmitter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and back-to-back framing.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 uart_txd
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int IDX_W   = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    generate
        if (BPS_CNT < 4) begin : g_bad_bps
            $error("uart_tx_param: CLK_FREQ/UART_BPS must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_EVEN) ? ^d : ~^d;
    endfunction

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [DATA_BITS-1:0] shift_p0;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 par_p0;
    logic                 par_nxt;
    logic                 txd_p0;
    logic                 txd_nxt;
    logic                 rdy_en;
    logic                 bit_end;
    logic                 last_stop;
    logic                 can_load;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;

    assign bit_end   = (cnt == CNT_LAST);
    assign last_stop = (state == S_STOP) && bit_end && (idx == STOP_LAST);
    // rdy_en holds off acceptance for the first cycle after reset.
    assign can_load  = rdy_en && ((state == S_IDLE) || last_stop);
    assign uart_txd  = txd_p0;

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (load),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready  = rdy_en && !fifo_full;
    assign load      = can_load && !fifo_empty;
    assign load_data = fifo_dout;
    assign tx_busy   = (state != S_IDLE) || !fifo_empty;
`else
    assign tx_ready  = can_load;
    assign load      = tx_valid && can_load;
    assign load_data = tx_data;
    assign tx_busy   = (state != S_IDLE);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? '0 : cnt + CNT_W'(1);
        idx_nxt   = idx;
        shift_nxt = shift_p0;
        par_nxt   = par_p0;
        txd_nxt   = 1'b1;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_p0 >> 1;
                    if (idx == DATA_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    idx_nxt   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A load in the last stop cycle overrides the return to IDLE.
        if (load) begin
            state_nxt = S_START;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            shift_nxt = load_data;
            par_nxt   = parity_bit(load_data);
        end

        case (state_nxt)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = shift_nxt[0];
            S_PARITY: txd_nxt = par_nxt;
            default:  txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            rdy_en <= 1'b0;
            txd_p0 <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            rdy_en <= 1'b1;
            txd_p0 <= txd_nxt;
        end
    end

    // Stage p0: character and parity held for the duration of the frame.
    always_ff @(posedge clk) begin
        shift_p0 <= shift_nxt;
        par_p0   <= par_nxt;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three parameter sets driven in sequence,
// expected line levels queued per cycle and compared by a monitor.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50000000;
    localparam int BPS      = 5000000;
    localparam int BPS_CNT  = 10;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       vld  [3];
    logic [8:0] dat  [3];
    logic       rdy  [3];
    logic       busy [3];
    logic       txd  [3];

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    bit expq [3][$];

    always #10 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .sys_rst(sys_rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx_busy(busy[0]), .uart_txd(txd[0]));

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .sys_rst(sys_rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .tx_busy(busy[1]), .uart_txd(txd[1]));

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .sys_rst(sys_rst), .tx_valid(vld[2]), .tx_data(dat[2][6:0]),
        .tx_ready(rdy[2]), .tx_busy(busy[2]), .uart_txd(txd[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbits(input int u);
        return (u == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int u);
        return (u == 1) ? PARITY_EVEN : ((u == 2) ? PARITY_ODD : PARITY_NONE);
    endfunction

    function automatic int nstop(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    // Expected line level for every cycle of one frame, starting with the cycle
    // after the accepting edge (one extra idle cycle when a FIFO pop intervenes).
    task automatic push_frame(input int u, input logic [8:0] d, input bit pad);
        bit p;
        p = 1'b0;
        if (pad) expq[u].push_back(1'b1);
        repeat (BPS_CNT) expq[u].push_back(1'b0);
        for (int i = 0; i < nbits(u); i++) begin
            p = p ^ d[i];
            repeat (BPS_CNT) expq[u].push_back(d[i]);
        end
        if (pmode(u) == PARITY_EVEN) repeat (BPS_CNT) expq[u].push_back(p);
        if (pmode(u) == PARITY_ODD)  repeat (BPS_CNT) expq[u].push_back(~p);
        repeat (nstop(u) * BPS_CNT) expq[u].push_back(1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int u = 0; u < 3; u++) begin
                bit e;
                e = (expq[u].size() > 0) ? expq[u].pop_front() : 1'b1;
                check($sformatf("txd%0d", u), {31'd0, txd[u]}, {31'd0, e});
            end
        end
    end

    task automatic xfer(input int u, input logic [8:0] d, input bit keep);
        int g;
        bit pad;
        g = 0;
        dat[u] = d;
        vld[u] = 1'b1;
        while (rdy[u] !== 1'b1 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) begin
            check($sformatf("ready_timeout%0d", u), {31'd0, rdy[u]}, 32'd1);
            vld[u] = 1'b0;
            return;
        end
        @(posedge clk);
        pad = FIFO_ON && (expq[u].size() == 0);
        push_frame(u, d, pad);
        #1;
        if (!keep) vld[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int g;
        g = 0;
        while (expq[u].size() > 0 && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check($sformatf("drain%0d", u), expq[u].size(), 32'd0);
        check($sformatf("busy_end%0d", u), {31'd0, busy[u]}, 32'd0);
    endtask

    initial begin
        logic [8:0] fbytes [5];
        fbytes = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h5A};

        for (int u = 0; u < 3; u++) begin
            vld[u] = 1'b0;
            dat[u] = '0;
        end
        sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_txd%0d", u),   {31'd0, txd[u]},  32'd1);
            check($sformatf("rst_ready%0d", u), {31'd0, rdy[u]},  32'd0);
            check($sformatf("rst_busy%0d", u),  {31'd0, busy[u]}, 32'd0);
        end
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check($sformatf("ready_after_rst%0d", u), {31'd0, rdy[u]}, 32'd1);
        mon_on = 1'b1;

        // 8N1 0xA5, with tx_ready only in the last stop cycle
        xfer(0, 9'hA5, 1'b0);
`ifndef UART_TX_FIFO_EN
        for (int k = 0; k < 100; k++) begin
            check($sformatf("ready_k%0d", k), {31'd0, rdy[0]}, (k == 99) ? 32'd1 : 32'd0);
            if (k == 10) check("busy_mid", {31'd0, busy[0]}, 32'd1);
            @(posedge clk);
            #1;
        end
`endif
        wait_done(0);

        // 8E2 0x07 and 7O1 0x7F
        xfer(1, 9'h07, 1'b0);
        check("busy_b", {31'd0, busy[1]}, 32'd1);
        wait_done(1);
        xfer(2, 9'h7F, 1'b0);
        wait_done(2);

        // back-to-back with tx_valid held
        xfer(0, 9'h55, 1'b1);
        xfer(0, 9'hAA, 1'b0);
        wait_done(0);

        // reset during data bit 3
        xfer(0, 9'hC3, 1'b0);
        repeat (44) @(posedge clk);
        #1;
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        expq[0].delete();
        check("abort_txd",   {31'd0, txd[0]},  32'd1);
        check("abort_ready", {31'd0, rdy[0]},  32'd0);
        check("abort_busy",  {31'd0, busy[0]}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_ready_back", {31'd0, rdy[0]}, 32'd1);
        xfer(0, 9'h3C, 1'b0);
        wait_done(0);

`ifdef UART_TX_FIFO_EN
        // five pushes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) xfer(0, fbytes[i], 1'b1);
        check("fifo_full_ready", {31'd0, rdy[0]},  32'd0);
        check("fifo_busy",       {31'd0, busy[0]}, 32'd1);
        vld[0] = 1'b0;
        wait_done(0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
